// File: rtl/cache_ctrl_assoc_pkg.sv
// Shared definitions for the 2-way set-associative MEM-stage cache controller:
// controller states and address-field width helpers.
package cache_ctrl_assoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_MISS,
        ST_WR
    } state_e;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(input int sets, input int line_words);
        return 30 - off_w(line_words) - idx_w(sets);
    endfunction

    // Word selectors keep at least one bit so single-word lines still elaborate.
    function automatic int off_sel_w(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/cache_ctrl_assoc_way.sv
// One way of the cache: per-set valid bit, tag and line data with a
// combinational read port, a whole-line fill port and a single-word write port.
module cache_way_array #(
    parameter int IDX_W      = 6,
    parameter int TAG_W      = 23,
    parameter int OFF_SW     = 1,
    parameter int LINE_WORDS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [IDX_W-1:0]           idx_i,
    output logic                       valid_o,
    output logic [TAG_W-1:0]           tag_o,
    output logic [32*LINE_WORDS-1:0]   line_o,
    input  logic                       fill_i,
    input  logic [TAG_W-1:0]           fill_tag_i,
    input  logic [32*LINE_WORDS-1:0]   fill_line_i,
    input  logic                       wr_i,
    input  logic [OFF_SW-1:0]          wr_off_i,
    input  logic [31:0]                wr_word_i
);
    localparam int SETS = 1 << IDX_W;

    logic [SETS-1:0]         valid_q;
    logic [TAG_W-1:0]        tag_q  [SETS];
    logic [32*LINE_WORDS-1:0] data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays have no reset; a clear valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (fill_i) begin
            tag_q[idx_i]  <= fill_tag_i;
            data_q[idx_i] <= fill_line_i;
        end else if (wr_i) begin
            data_q[idx_i][32*int'(wr_off_i) +: 32] <= wr_word_i;
        end
    end

endmodule

// File: rtl/cache_ctrl_assoc.sv
// 2-way LRU, write-through, no-write-allocate data cache between the MEM stage
// and the SRAM controller, with single-cycle flush.
module cache_ctrl_assoc
    import cache_ctrl_assoc_pkg::*;
#(
    parameter int          SETS       = 64,
    parameter int          LINE_WORDS = 2,
    parameter logic [31:0] BASE_ADDR  = 32'd1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               address,
    input  logic [31:0]               wdata,
    input  logic                      memRead,
    input  logic                      memWrite,
    input  logic                      flush,
    output logic [31:0]               rdata,
    output logic                      ready,
    output logic [31:0]               sramAddress,
    output logic [31:0]               sramWriteData,
    output logic                      sramWrEn,
    output logic                      sramRdEn,
    input  logic [32*LINE_WORDS-1:0]  sramReadData,
    input  logic                      sramReady
);
    localparam int          OFF_W     = off_w(LINE_WORDS);
    localparam int          IDX_W     = idx_w(SETS);
    localparam int          TAG_W     = tag_w(SETS, LINE_WORDS);
    localparam int          OFF_SW    = off_sel_w(LINE_WORDS);
    localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS) * 32'd4 - 32'd1);

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [SETS-1:0]  lru_q;

    logic [31:0]      lk_addr, lk_eff;
    logic [OFF_SW-1:0] lk_off;
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;

    // Outside IDLE the pipeline inputs are not trusted; decode the latched request.
    assign lk_addr = (state_q == ST_IDLE) ? address : addr_q;
    assign lk_eff  = lk_addr - BASE_ADDR;
    assign lk_off  = OFF_SW'((lk_eff >> 2) & 32'(LINE_WORDS - 1));
    assign lk_idx  = lk_eff[2+OFF_W +: IDX_W];
    assign lk_tag  = lk_eff[31 -: TAG_W];

    logic [1:0]              way_valid, way_hit, way_fill, way_wr;
    logic [TAG_W-1:0]        way_tag  [2];
    logic [32*LINE_WORDS-1:0] way_line [2];
    logic                    fill_en, wr_en, lru_upd, lru_val, flush_en;
    logic                    victim, hit, hit_way;
    logic [32*LINE_WORDS-1:0] hit_line;

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .IDX_W      (IDX_W),
            .TAG_W      (TAG_W),
            .OFF_SW     (OFF_SW),
            .LINE_WORDS (LINE_WORDS)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush_en),
            .idx_i       (lk_idx),
            .valid_o     (way_valid[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w]),
            .fill_i      (way_fill[w]),
            .fill_tag_i  (lk_tag),
            .fill_line_i (sramReadData),
            .wr_i        (way_wr[w]),
            .wr_off_i    (lk_off),
            .wr_word_i   (wdata_q)
        );
        assign way_hit[w]  = way_valid[w] && (way_tag[w] == lk_tag);
        assign way_fill[w] = fill_en && (int'(victim) == w);
        assign way_wr[w]   = wr_en && way_hit[w];
    end

    assign hit      = |way_hit;
    assign hit_way  = way_hit[1];
    assign hit_line = way_line[hit_way];
    assign victim   = lru_q[lk_idx];

    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata         = '0;
        ready         = 1'b0;
        sramAddress   = '0;
        sramWriteData = '0;
        sramRdEn      = 1'b0;
        sramWrEn      = 1'b0;
        fill_en       = 1'b0;
        wr_en         = 1'b0;
        lru_upd       = 1'b0;
        lru_val       = 1'b0;
        flush_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    flush_en = 1'b1;
                end else if (memWrite) begin
                    addr_d  = address;
                    wdata_d = wdata;
                    state_d = ST_WR;
                end else if (memRead) begin
                    if (hit) begin
                        ready   = 1'b1;
                        rdata   = hit_line[32*int'(lk_off) +: 32];
                        lru_upd = 1'b1;
                        lru_val = ~hit_way;
                    end else begin
                        addr_d  = address;
                        state_d = ST_RD_MISS;
                    end
                end else begin
                    ready = 1'b1;
                end
            end
            ST_RD_MISS: begin
                sramRdEn    = 1'b1;
                sramAddress = BASE_ADDR + (lk_eff & LINE_MASK);
                if (sramReady) begin
                    ready   = 1'b1;
                    rdata   = sramReadData[32*int'(lk_off) +: 32];
                    fill_en = 1'b1;
                    lru_upd = 1'b1;
                    lru_val = ~victim;
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                sramWrEn      = 1'b1;
                sramAddress   = addr_q;
                sramWriteData = wdata_q;
                if (sramReady) begin
                    ready = 1'b1;
                    if (hit) begin
                        wr_en   = 1'b1;
                        lru_upd = 1'b1;
                        lru_val = ~hit_way;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            lru_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (flush_en) begin
                lru_q <= '0;
            end else if (lru_upd) begin
                lru_q[lk_idx] <= lru_val;
            end
        end
    end

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Bench for cache_ctrl_assoc: directed vector table, hand-written corner
// sequences, then random traffic against a recency-list cache model.
module tb_cache_ctrl_assoc;

    localparam int          TB_SETS = 64;
    localparam int          TB_LW   = 2;
    localparam logic [31:0] BASE    = 32'd1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata;
    logic        memRead, memWrite, flush;
    logic [31:0] rdata;
    logic        ready;
    logic [31:0] sramAddress, sramWriteData;
    logic        sramWrEn, sramRdEn;
    logic [63:0] sramReadData;
    logic        sramReady;

    int total = 0;
    int bad   = 0;

    cache_ctrl_assoc #(.SETS(TB_SETS), .LINE_WORDS(TB_LW), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .address       (address),
        .wdata         (wdata),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .flush         (flush),
        .rdata         (rdata),
        .ready         (ready),
        .sramAddress   (sramAddress),
        .sramWriteData (sramWriteData),
        .sramWrEn      (sramWrEn),
        .sramRdEn      (sramRdEn),
        .sramReadData  (sramReadData),
        .sramReady     (sramReady)
    );

    always #5 clk = ~clk;

    // SRAM contents (word-indexed relative to BASE) and the cache model:
    // per set, resident tags ordered least- to most-recently used.
    logic [31:0] mem [int unsigned];
    int unsigned tagq [TB_SETS][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    function automatic int unsigned key_of(input logic [31:0] a);
        return (a - BASE) >> 2;
    endfunction

    function automatic logic [31:0] mem_word(input int unsigned k);
        if (mem.exists(k)) return mem[k];
        return (k * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic int unsigned set_of(input logic [31:0] a);
        return ((a - BASE) / (TB_LW * 4)) % TB_SETS;
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return (a - BASE) / (TB_LW * 4 * TB_SETS);
    endfunction

    function automatic bit model_has(input logic [31:0] a);
        int unsigned s = set_of(a);
        foreach (tagq[s][i]) if (tagq[s][i] == tag_of(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_access(input logic [31:0] a, input bit allocate);
        int unsigned s = set_of(a);
        int unsigned t = tag_of(a);
        foreach (tagq[s][i]) begin
            if (tagq[s][i] == t) begin
                tagq[s].delete(i);
                tagq[s].push_back(t);
                return;
            end
        end
        if (allocate) begin
            if (tagq[s].size() == 2) void'(tagq[s].pop_front());
            tagq[s].push_back(t);
        end
    endfunction

    function automatic void model_clear();
        for (int s = 0; s < TB_SETS; s++) tagq[s].delete();
    endfunction

    // All sequence tasks start and end 1 time unit after a rising edge.
    task automatic do_load(input logic [31:0] a, input bit exp_hit, input logic [31:0] exp_data,
                           input int lat);
        int unsigned kb;
        address = a; memRead = 1'b1; memWrite = 1'b0;
        #1;
        if (exp_hit) begin
            check_bit("ld_hit_ready", ready, 1'b1);
            check("ld_hit_rdata", rdata, exp_data);
            check_bit("ld_hit_no_rden", sramRdEn, 1'b0);
            @(posedge clk); #1;
        end else begin
            check_bit("ld_miss_ready", ready, 1'b0);
            @(posedge clk); #1;
            address = ~a;
            for (int i = 0; i <= lat; i++) begin
                check_bit("rd_en", sramRdEn, 1'b1);
                check_bit("rd_no_wren", sramWrEn, 1'b0);
                check("rd_addr", sramAddress, a & ~32'h7);
                check_bit("rd_wait_ready", ready, 1'b0);
                if (i < lat) begin @(posedge clk); #1; end
            end
            kb = key_of(a) & ~32'd1;
            sramReadData = {mem_word(kb + 1), mem_word(kb)};
            sramReady = 1'b1;
            #1;
            check_bit("rd_done_ready", ready, 1'b1);
            check("rd_done_rdata", rdata, exp_data);
            @(posedge clk); #1;
            sramReady = 1'b0;
        end
        memRead = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit both, input int lat);
        address = a; wdata = d; memWrite = 1'b1; memRead = both;
        #1;
        check_bit("st_idle_ready", ready, 1'b0);
        check_bit("st_idle_wren", sramWrEn, 1'b0);
        @(posedge clk); #1;
        address = ~a; wdata = ~d;
        for (int i = 0; i <= lat; i++) begin
            check_bit("wr_en", sramWrEn, 1'b1);
            check_bit("wr_no_rden", sramRdEn, 1'b0);
            check("wr_addr", sramAddress, a);
            check("wr_data", sramWriteData, d);
            check_bit("wr_wait_ready", ready, 1'b0);
            if (i < lat) begin @(posedge clk); #1; end
        end
        sramReady = 1'b1;
        #1;
        check_bit("wr_done_ready", ready, 1'b1);
        @(posedge clk); #1;
        sramReady = 1'b0;
        mem[key_of(a)] = d;
        memWrite = 1'b0; memRead = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        check_bit("flush_ready", ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic do_idle();
        #1;
        check_bit("idle_ready", ready, 1'b1);
        check("idle_rdata", rdata, 32'h0);
        check_bit("idle_rden", sramRdEn, 1'b0);
        check_bit("idle_wren", sramWrEn, 1'b0);
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] tag, set;
        tag = ($urandom_range(9) == 0) ? 32'h007F_FFFF : 32'($urandom_range(3));
        set = ($urandom_range(7) == 0) ? 32'd63 : 32'($urandom_range(3));
        return BASE + tag * 32'd512 + set * 32'd8 + 32'($urandom_range(1)) * 32'd4
               + 32'($urandom_range(3));
    endfunction

    typedef enum {OP_LD, OP_ST, OP_FL, OP_IDLE} op_e;
    typedef struct {
        op_e         op;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] a, d;
    int unsigned r, lat;
    bit          h;

    initial begin
        mem[0] = 32'hA; mem[1] = 32'hB;
        mem[128] = 32'h0000_C000; mem[129] = 32'h0000_C001; mem[256] = 32'h0000_D000;

        tbl.push_back('{OP_LD,   32'd1024, 32'h0,  1'b0, 32'hA});
        tbl.push_back('{OP_LD,   32'd1028, 32'h0,  1'b1, 32'hB});
        tbl.push_back('{OP_LD,   32'd1536, 32'h0,  1'b0, 32'h0000_C000});
        tbl.push_back('{OP_LD,   32'd1024, 32'h0,  1'b1, 32'hA});
        tbl.push_back('{OP_LD,   32'd2048, 32'h0,  1'b0, 32'h0000_D000});
        tbl.push_back('{OP_LD,   32'd1024, 32'h0,  1'b1, 32'hA});
        tbl.push_back('{OP_LD,   32'd1536, 32'h0,  1'b0, 32'h0000_C000});
        tbl.push_back('{OP_ST,   32'd1024, 32'h55, 1'b0, 32'h0});
        tbl.push_back('{OP_LD,   32'd1024, 32'h0,  1'b1, 32'h55});
        tbl.push_back('{OP_ST,   32'd4096, 32'h77, 1'b0, 32'h0});
        tbl.push_back('{OP_LD,   32'd1024, 32'h0,  1'b1, 32'h55});
        tbl.push_back('{OP_LD,   32'd4096, 32'h0,  1'b0, 32'h77});
        tbl.push_back('{OP_LD,   32'd1028, 32'h0,  1'b1, 32'hB});
        tbl.push_back('{OP_LD,   32'd1536, 32'h0,  1'b0, 32'h0000_C000});
        tbl.push_back('{OP_IDLE, 32'd0,    32'h0,  1'b0, 32'h0});
        tbl.push_back('{OP_FL,   32'd0,    32'h0,  1'b0, 32'h0});
        tbl.push_back('{OP_LD,   32'd1024, 32'h0,  1'b0, 32'h55});
        tbl.push_back('{OP_LD,   32'd1540, 32'h0,  1'b0, 32'h0000_C001});

        rst = 1'b1; address = '0; wdata = '0; memRead = 1'b0; memWrite = 1'b0; flush = 1'b0;
        sramReadData = '0; sramReady = 1'b0;
        #1;
        check_bit("reset_ready", ready, 1'b1);
        check("reset_rdata", rdata, 32'h0);
        check_bit("reset_rden", sramRdEn, 1'b0);
        check_bit("reset_wren", sramWrEn, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            case (tbl[i].op)
                OP_LD:   do_load(tbl[i].addr, tbl[i].exp_hit, tbl[i].exp_rdata, i % 4);
                OP_ST:   do_store(tbl[i].addr, tbl[i].data, 1'b0, i % 3);
                OP_FL:   do_flush();
                default: do_idle();
            endcase
        end

        // Flush together with a load: flush wins, the load then misses.
        address = 32'd1024; memRead = 1'b1; flush = 1'b1;
        #1;
        check_bit("flush_rd_ready", ready, 1'b0);
        check_bit("flush_rd_rden", sramRdEn, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        do_load(32'd1024, 1'b0, 32'h55, 2);

        // Asynchronous reset in the middle of a line fill.
        address = 32'd2048; memRead = 1'b1;
        #1;
        check_bit("rst_seq_miss", ready, 1'b0);
        @(posedge clk); #1;
        check_bit("rst_seq_rden", sramRdEn, 1'b1);
        #2;
        rst = 1'b1; memRead = 1'b0;
        #1;
        check_bit("rst_async_rden", sramRdEn, 1'b0);
        check_bit("rst_async_ready", ready, 1'b1);
        check("rst_async_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        sramReadData = {mem_word(257), mem_word(256)};
        sramReady = 1'b1;
        #1;
        check_bit("late_rdy_rden", sramRdEn, 1'b0);
        check_bit("late_rdy_ready", ready, 1'b1);
        check("late_rdy_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        sramReady = 1'b0;
        do_load(32'd1024, 1'b0, 32'h55, 1);

        // Load and store requested together take the write path.
        do_store(32'd1024, 32'h99, 1'b1, 2);
        do_load(32'd1024, 1'b1, 32'h99, 0);
        do_idle();

        // Random traffic against the model, from a clean reset.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        for (int n = 0; n < 400; n++) begin
            r   = $urandom_range(99);
            a   = rand_addr();
            lat = $urandom_range(3);
            if (r < 55) begin
                h = model_has(a);
                do_load(a, h, mem_word(key_of(a)), int'(lat));
                model_access(a, 1'b1);
            end else if (r < 80) begin
                d = $urandom;
                do_store(a, d, r >= 72, int'(lat));
                model_access(a, 1'b0);
            end else if (r < 85) begin
                do_flush();
                model_clear();
            end else begin
                do_idle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
